switch_debouncer: RTL and testbench

Upstream conditioning stage for the slide-switch/push-button PIO input of the reaction tester. Brings asynchronous, bouncing board inputs into the `clk` domain through a multi-flop synchronizer. Debounces each bit independently with a per-bit counter FSM. Delivers a clean level bus that drives the PIO `in_port`, plus one-cycle rise/fall pulses for timing logic.

---
 rtl/debounce_pkg.sv | 9 +
 rtl/debounce_bit.sv | 72 +++++++
 rtl/switch_debouncer.sv | 39 +++
 tb/tb_switch_debouncer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding, counter sizing and default constants for the switch debouncer
package debounce_pkg;
  typedef enum logic {S_STABLE, S_PENDING} deb_state_t;
  localparam int DEB_CYCLES_50MHZ_10MS = 500000;
  localparam int SYNC_STAGES_DEFAULT = 2;
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: synchronizer, qualification FSM, counter and edge pulses for one input bit
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEB_CYCLES_50MHZ_10MS,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic busy
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic sync;
  deb_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic clean_n, rise_n, fall_n;
  assign sync = sync_q[SYNC_STAGES-1];
  assign busy = (state == S_PENDING);
  // shift the raw pin through the synchronizer chain; reset level matches clean so no edge on release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= {SYNC_STAGES{INIT_LEVEL}};
    else sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end
  // state, counter, debounced level and one-cycle pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_STABLE;
      cnt <= '0;
      clean <= INIT_LEVEL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      clean <= clean_n;
      rise <= rise_n;
      fall <= fall_n;
    end
  end
  // qualify a difference between sync and clean; any return to the clean level restarts from scratch
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    clean_n = clean;
    rise_n = 1'b0;
    fall_n = 1'b0;
    if (state == S_STABLE) begin
      if (sync != clean) begin
        state_n = S_PENDING;
        cnt_n = CW'(1);
      end
    end else if (sync == clean) begin
      state_n = S_STABLE;
      cnt_n = '0;
    end else if (cnt == LAST) begin
      state_n = S_STABLE;
      cnt_n = '0;
      clean_n = ~clean;
      rise_n = ~clean;
      fall_n = clean;
    end else begin
      cnt_n = cnt + CW'(1);
    end
  end
endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: per-bit synchronize and debounce of switch/button pins with rise/fall pulses
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEB_CYCLES_50MHZ_10MS,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] busy
);
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("switch_debouncer: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
    $error("switch_debouncer: DEBOUNCE_CYCLES must be >= 2");
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INIT_LEVEL(INIT_LEVEL)
    ) u_bit (
      .clk(clk),
      .reset_n(reset_n),
      .raw(raw_in[i]),
      .clean(clean_out[i]),
      .rise(rise_pulse[i]),
      .fall(fall_pulse[i]),
      .busy(busy[i])
    );
  end
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: scoreboard bench; stimulus queues expected edges and level probes, a monitor checks them
module tb_switch_debouncer;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [7:0] raw_in = 8'h00;
  logic [7:0] clean_out, rise_pulse, fall_pulse, busy;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int c, d;
  logic finish_req = 1'b0;
  typedef struct {int cyc; logic [7:0] rise; logic [7:0] fall; logic [7:0] clean;} edge_t;
  typedef struct {int cyc; int sel; logic [7:0] mask; logic [7:0] val; string name;} probe_t;
  edge_t eq[$];
  probe_t pq[$];
  edge_t e;
  probe_t p;
  logic [7:0] act;

  switch_debouncer #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .INIT_LEVEL(1'b0)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .raw_in(raw_in),
    .clean_out(clean_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_edge(input int at, input logic [7:0] r, input logic [7:0] f, input logic [7:0] cl);
    edge_t x;
    x.cyc = at; x.rise = r; x.fall = f; x.clean = cl;
    eq.push_back(x);
  endtask

  task automatic probe(input int at, input int sel, input logic [7:0] mask, input logic [7:0] val, input string name);
    probe_t x;
    x.cyc = at; x.sel = sel; x.mask = mask; x.val = val; x.name = name;
    pq.push_back(x);
  endtask

  task automatic step_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // monitor: level probes due this cycle, every output pulse against the edge scoreboard, final drain check
  always @(negedge clk) begin
    for (int i = pq.size() - 1; i >= 0; i--) begin
      if (pq[i].cyc == cyc) begin
        p = pq[i];
        pq.delete(i);
        act = (p.sel == 0) ? clean_out : (p.sel == 1) ? busy : (rise_pulse | fall_pulse);
        total++;
        if ((act & p.mask) !== p.val) begin
          bad++;
          $display("FAIL %s cyc=%0d actual=%h expected=%h", p.name, cyc, act & p.mask, p.val);
        end
      end
    end
    if ((rise_pulse | fall_pulse) != 8'h00) begin
      total++;
      if (eq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d rise=%h fall=%h clean=%h", cyc, rise_pulse, fall_pulse, clean_out);
      end else begin
        e = eq.pop_front();
        if (cyc != e.cyc || rise_pulse !== e.rise || fall_pulse !== e.fall || clean_out !== e.clean || (rise_pulse & fall_pulse) != 8'h00) begin
          bad++;
          $display("FAIL edge cyc=%0d rise=%h fall=%h clean=%h expected cyc=%0d rise=%h fall=%h clean=%h",
                   cyc, rise_pulse, fall_pulse, clean_out, e.cyc, e.rise, e.fall, e.clean);
        end
      end
    end
    if (finish_req) begin
      total++;
      if (eq.size() != 0 || pq.size() != 0) begin
        bad++;
        $display("FAIL leftover actual edges=%0d probes=%0d expected 0", eq.size(), pq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #1 reset_n = 1'b0;
    raw_in = 8'hFF;
    step_to(3);
    c = cyc;
    probe(c, 0, 8'hFF, 8'h00, "rst_clean");
    probe(c, 1, 8'hFF, 8'h00, "rst_busy");
    probe(c, 2, 8'hFF, 8'h00, "rst_pulse");
    reset_n = 1'b1;
    probe(c + 5, 0, 8'hFF, 8'h00, "rel_clean_pre");
    expect_edge(c + 6, 8'hFF, 8'h00, 8'hFF);
    probe(c + 7, 2, 8'hFF, 8'h00, "rel_pulse_once");
    probe(c + 7, 0, 8'hFF, 8'hFF, "rel_clean_post");
    step_to(c + 8);
    c = cyc;
    raw_in = 8'h00;
    expect_edge(c + 6, 8'h00, 8'hFF, 8'h00);
    step_to(c + 8);
    c = cyc;
    raw_in = 8'h01;
    for (int k = 1; k <= 7; k++) probe(c + k, 1, 8'h01, (k >= 3 && k <= 5) ? 8'h01 : 8'h00, "rise_busy0");
    probe(c + 5, 0, 8'hFF, 8'h00, "rise_clean_pre");
    expect_edge(c + 6, 8'h01, 8'h00, 8'h01);
    probe(c + 7, 2, 8'hFF, 8'h00, "rise_pulse_once");
    step_to(c + 8);
    c = cyc;
    raw_in = 8'h00;
    expect_edge(c + 6, 8'h00, 8'h01, 8'h00);
    step_to(c + 8);
    c = cyc;
    raw_in = 8'h08;
    probe(c + 4, 1, 8'h08, 8'h08, "glitch_busy_hi");
    probe(c + 8, 1, 8'h08, 8'h00, "glitch_busy_lo");
    for (int k = 1; k <= 10; k++) probe(c + k, 0, 8'hFF, 8'h00, "glitch_clean");
    step_to(c + 3);
    raw_in = 8'h00;
    step_to(c + 12);
    c = cyc;
    raw_in = 8'h04;
    probe(c + 9, 0, 8'hFF, 8'h00, "bounce_clean_pre");
    expect_edge(c + 10, 8'h04, 8'h00, 8'h04);
    step_to(c + 1);
    raw_in = 8'h00;
    step_to(c + 2);
    raw_in = 8'h04;
    step_to(c + 3);
    raw_in = 8'h00;
    step_to(c + 4);
    raw_in = 8'h04;
    step_to(c + 14);
    c = cyc;
    raw_in = 8'h0F;
    expect_edge(c + 6, 8'h0B, 8'h00, 8'h0F);
    step_to(c + 8);
    c = cyc;
    raw_in = 8'hF0;
    probe(c + 5, 0, 8'hFF, 8'h0F, "simul_clean_pre");
    expect_edge(c + 6, 8'hF0, 8'h0F, 8'hF0);
    probe(c + 7, 2, 8'hFF, 8'h00, "simul_pulse_once");
    step_to(c + 8);
    c = cyc;
    raw_in = 8'h0F;
    expect_edge(c + 6, 8'h0F, 8'hF0, 8'h0F);
    step_to(c + 8);
    c = cyc;
    raw_in = 8'h2F;
    probe(c + 3, 1, 8'hFF, 8'h20, "midp_busy");
    probe(c + 4, 0, 8'hFF, 8'h00, "midp_rst_clean");
    probe(c + 4, 1, 8'hFF, 8'h00, "midp_rst_busy");
    step_to(c + 3);
    @(negedge clk);
    #1 reset_n = 1'b0;
    step_to(c + 6);
    reset_n = 1'b1;
    d = cyc;
    probe(d + 5, 0, 8'hFF, 8'h00, "midp_clean_pre");
    expect_edge(d + 6, 8'h2F, 8'h00, 8'h2F);
    step_to(d + 10);
    finish_req = 1'b1;
  end
endmodule
